rect_fill_engine: RTL and testbench

//  GPU-side pixel generator feeding the frame buffer write port. Accepts one

---
 rtl/rect_fill_engine.sv | 128 ++++++++++++
 tb/tb_rect_fill_engine.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// Filled-rectangle pixel generator: accepts one clipped rectangle command and
// streams one frame-buffer write per clock in raster order.
module rect_fill_engine #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 240
) (
  input  logic        gpu_clk_150,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [9:0]  cmd_y0,
  input  logic [9:0]  cmd_x1,
  input  logic [9:0]  cmd_y1,
  input  logic [3:0]  cmd_color,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [9:0]  gpu_x,
  output logic [9:0]  gpu_y,
  output logic [3:0]  gpu_data,
  output logic        gpu_we
);

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 4;
  localparam logic [CW-1:0] X_MAX = CW'(H_RES - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(V_RES - 1);
  localparam logic [CW-1:0] X_LIM = CW'(H_RES);
  localparam logic [CW-1:0] Y_LIM = CW'(V_RES);

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state, state_n;
  logic [CW-1:0] x0_q, x1c_q, y1c_q;
  logic [CW-1:0] x0_n, x1c_n, y1c_n;
  logic [CW-1:0] x_n, y_n;
  logic [DW-1:0] data_n;
  logic          we_n, done_n, busy_n, ready_n;
  logic [CW-1:0] x1c_c, y1c_c;
  logic          empty_c;

  // Clip the incoming corners to the screen and detect empty rectangles.
  assign x1c_c   = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
  assign y1c_c   = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
  assign empty_c = (cmd_x0 > x1c_c) || (cmd_y0 > y1c_c) ||
                   (cmd_x0 >= X_LIM) || (cmd_y0 >= Y_LIM);

  // Next-state and next-output logic; gpu_data doubles as the latched colour.
  always_comb begin
    state_n = state;
    x0_n    = x0_q;
    x1c_n   = x1c_q;
    y1c_n   = y1c_q;
    x_n     = gpu_x;
    y_n     = gpu_y;
    data_n  = gpu_data;
    we_n    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (empty_c) begin
            done_n = 1'b1;
          end else begin
            x0_n    = cmd_x0;
            x1c_n   = x1c_c;
            y1c_n   = y1c_c;
            x_n     = cmd_x0;
            y_n     = cmd_y0;
            data_n  = cmd_color;
            we_n    = 1'b1;
            state_n = FILL;
          end
        end
      end
      FILL: begin
        if (abort) begin
          state_n = IDLE;
        end else if ((gpu_x == x1c_q) && (gpu_y == y1c_q)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          we_n = 1'b1;
          if (gpu_x == x1c_q) begin
            x_n = x0_q;
            y_n = gpu_y + CW'(1);
          end else begin
            x_n = gpu_x + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
    busy_n  = (state_n == FILL);
  end

  // State, latched command and registered outputs.
  always_ff @(posedge gpu_clk_150 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x0_q      <= '0;
      x1c_q     <= '0;
      y1c_q     <= '0;
      gpu_x     <= '0;
      gpu_y     <= '0;
      gpu_data  <= '0;
      gpu_we    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_n;
      x0_q      <= x0_n;
      x1c_q     <= x1c_n;
      y1c_q     <= y1c_n;
      gpu_x     <= x_n;
      gpu_y     <= y_n;
      gpu_data  <= data_n;
      gpu_we    <= we_n;
      done      <= done_n;
      busy      <= busy_n;
      cmd_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: raster order, timing, clipping,
// empty commands, abort, reset mid-fill and back-to-back commands.
module tb_rect_fill_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [9:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [3:0] cmd_color;
  logic       abort, busy, done;
  logic [9:0] gpu_x, gpu_y;
  logic [3:0] gpu_data;
  logic       gpu_we;

  rect_fill_engine dut (
    .gpu_clk_150(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .abort(abort), .busy(busy), .done(done),
    .gpu_x(gpu_x), .gpu_y(gpu_y), .gpu_data(gpu_data), .gpu_we(gpu_we)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int d; int c;} wr_t;
  wr_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  acc;

  // Cycle counter and output monitor sampled on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (gpu_we) wq.push_back('{int'(gpu_x), int'(gpu_y), int'(gpu_data), cyc});
    if (done) dq.push_back(cyc);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int writes_after(input int c);
    int n = 0;
    foreach (wq[i]) if (wq[i].c > c) n++;
    return n;
  endfunction

  function automatic int dones_after(input int c);
    int n = 0;
    foreach (dq[i]) if (dq[i] > c) n++;
    return n;
  endfunction

  // Present a command once the engine is ready; acc is the handshake cycle.
  task automatic issue(input int x0, input int y0, input int x1, input int y1,
                       input int col, input bit ab);
    @(negedge clk);
    for (int k = 0; k < 200 && !cmd_ready; k++) @(negedge clk);
    chk("ready_before_issue", int'(cmd_ready), 1);
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
    cmd_color = 4'(col); cmd_valid = 1'b1; abort = ab;
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    cmd_x0 = 10'($urandom); cmd_y0 = 10'($urandom);
    cmd_x1 = 10'($urandom); cmd_y1 = 10'($urandom);
    cmd_color = 4'($urandom);
  endtask

  // Run one rectangle to completion and check every write against a model.
  task automatic run_rect(input string tag, input int x0, input int y0,
                          input int x1, input int y1, input int col, input bit ab);
    int x1c, y1c, n, errs, idx, ex, ey, dc;
    x1c = (x1 > 319) ? 319 : x1;
    y1c = (y1 > 239) ? 239 : y1;
    n = (x0 > x1c || y0 > y1c) ? 0 : (x1c - x0 + 1) * (y1c - y0 + 1);
    issue(x0, y0, x1, y1, col, ab);
    dc = -1;
    for (int k = 0; k < n + 20; k++) begin
      @(negedge clk); #1;
      if (dq.size() > 0 && dq[$] > acc) begin dc = dq[$]; break; end
    end
    chk({tag, "_done_cycle"}, dc - acc, n + 1);
    chk({tag, "_write_count"}, writes_after(acc), n);
    errs = 0; idx = 0; ex = x0; ey = y0;
    foreach (wq[i]) begin
      if (wq[i].c > acc) begin
        if (wq[i].x != ex || wq[i].y != ey || wq[i].d != col ||
            wq[i].c != acc + 1 + idx || wq[i].x > 319 || wq[i].y > 239) errs++;
        idx++;
        if (ex == x1c) begin ex = x0; ey++; end else ex++;
      end
    end
    chk({tag, "_pixel_errors"}, errs, 0);
  endtask

  initial begin
    int b_first, w, nd;
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", int'(gpu_we), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x", int'(gpu_x), 0);
    chk("rst_y", int'(gpu_y), 0);
    chk("rst_data", int'(gpu_data), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);

    run_rect("small", 2, 3, 3, 4, 10, 1'b0);
    chk("small_last_x", int'(gpu_x), 3);
    chk("small_last_y", int'(gpu_y), 4);
    run_rect("clip", 300, 230, 400, 500, 5, 1'b1);
    run_rect("empty_inv", 5, 5, 4, 9, 3, 1'b0);
    run_rect("empty_off", 320, 0, 330, 5, 3, 1'b0);
    run_rect("full", 0, 0, 319, 239, 0, 1'b0);
    run_rect("one", 319, 239, 319, 239, 15, 1'b0);

    // Reset mid-fill: writes stop immediately, no done.
    issue(0, 0, 9, 9, 7, 1'b0);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_we", int'(gpu_we), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_no_done", dones_after(acc), 0);
    run_rect("after_rst", 1, 1, 2, 1, 9, 1'b0);

    // Abort while the 5th pixel is on the bus.
    issue(0, 0, 9, 0, 6, 1'b0);
    for (int k = 0; k < 50 && cyc != acc + 5; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("abort_writes", writes_after(acc), 5);
    chk("abort_no_done", dones_after(acc), 0);

    // Back-to-back 1x1 commands: writes two cycles apart.
    issue(7, 7, 7, 7, 1, 1'b0);
    w = acc;
    issue(8, 8, 8, 8, 2, 1'b0);
    repeat (5) @(negedge clk);
    chk("b2b_accept_gap", acc - w, 2);
    b_first = -1; nd = 0;
    foreach (wq[i]) if (wq[i].c > w) begin
      nd++;
      if (wq[i].x == 8) b_first = wq[i].c;
    end
    chk("b2b_writes", nd, 2);
    chk("b2b_spacing", b_first - (w + 1), 2);
    chk("b2b_dones", dones_after(w), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
